// File: rtl/multiplier_datapath_pkg.sv
// Shared encodings for the multiplier controller / datapath interface.
// Both sides import this package so select and shift codes stay in sync.
package multiplier_datapath_pkg;

    // Partial-product operand select codes
    localparam logic [1:0] SEL_LL = 2'b00;
    localparam logic [1:0] SEL_LH = 2'b01;
    localparam logic [1:0] SEL_HL = 2'b10;
    localparam logic [1:0] SEL_HH = 2'b11;

    // Partial-product shift codes
    localparam logic [1:0] SHIFT_0    = 2'b00;
    localparam logic [1:0] SHIFT_HALF = 2'b01;
    localparam logic [1:0] SHIFT_FULL = 2'b10;
    localparam logic [1:0] SHIFT_NONE = 2'b11;

endpackage

// File: rtl/multiplier_datapath_mult4x4.sv
// Combinational unsigned HALF x HALF multiplier shared by all four steps.
module mult4x4 #(
    parameter int HALF = 4
) (
    input  logic [HALF-1:0]   a,
    input  logic [HALF-1:0]   b,
    output logic [2*HALF-1:0] p
);

    // Zero-extend both operands so the product is computed at full width
    assign p = {{HALF{1'b0}}, a} * {{HALF{1'b0}}, b};

endmodule

// File: rtl/multiplier_datapath.sv
// Four-step shift-and-add multiplier datapath driven by the multiplier controller.
// One HALF x HALF multiplier is reused; partial products accumulate into product.
module multiplier_datapath
    import multiplier_datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_a,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
    input  logic [1:0]         input_sel,
    input  logic [1:0]         shift_sel,
    input  logic               clk_ena,
    input  logic               sclr_n,
    output logic [1:0]         count,
    output logic [2*WIDTH-1:0] product,
    output logic               product_valid,
    output logic               seq_err
);

    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [HALF-1:0]    mul_a;
    logic [HALF-1:0]    mul_b;
    logic [WIDTH-1:0]   pp;
    logic [2*WIDTH-1:0] pp_ext;
    logic [2*WIDTH-1:0] addend;

    // Operand nibble selection from the registered operands
    always_comb begin
        mul_a = op_a[HALF-1:0];
        mul_b = op_b[HALF-1:0];
        case (input_sel)
            SEL_LL: begin
                mul_a = op_a[HALF-1:0];
                mul_b = op_b[HALF-1:0];
            end
            SEL_LH: begin
                mul_a = op_a[HALF-1:0];
                mul_b = op_b[WIDTH-1:HALF];
            end
            SEL_HL: begin
                mul_a = op_a[WIDTH-1:HALF];
                mul_b = op_b[HALF-1:0];
            end
            SEL_HH: begin
                mul_a = op_a[WIDTH-1:HALF];
                mul_b = op_b[WIDTH-1:HALF];
            end
            default: begin
                mul_a = op_a[HALF-1:0];
                mul_b = op_b[HALF-1:0];
            end
        endcase
    end

    mult4x4 #(
        .HALF(HALF)
    ) u_mult (
        .a(mul_a),
        .b(mul_b),
        .p(pp)
    );

    assign pp_ext = {{WIDTH{1'b0}}, pp};

    // SHIFT_NONE lets the controller burn a step without touching the accumulator
    always_comb begin
        addend = '0;
        case (shift_sel)
            SHIFT_0:    addend = pp_ext;
            SHIFT_HALF: addend = pp_ext << HALF;
            SHIFT_FULL: addend = pp_ext << WIDTH;
            SHIFT_NONE: addend = '0;
            default:    addend = '0;
        endcase
    end

    // Clear/load has priority over a step; otherwise hold
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            op_a          <= '0;
            op_b          <= '0;
            product       <= '0;
            count         <= 2'd0;
            product_valid <= 1'b0;
            seq_err       <= 1'b0;
        end else if (!sclr_n) begin
            op_a          <= dataa;
            op_b          <= datab;
            product       <= '0;
            count         <= 2'd0;
            product_valid <= 1'b0;
            seq_err       <= 1'b0;
        end else if (clk_ena) begin
            product       <= product + addend;
            count         <= count + 2'd1;
            product_valid <= (count == 2'd3);
            seq_err       <= seq_err | (input_sel != count);
        end
    end

endmodule

// File: tb/tb_multiplier_datapath.sv
// Directed self-checking bench for multiplier_datapath (WIDTH=8).
module tb_multiplier_datapath;
    import multiplier_datapath_pkg::*;

    localparam int WIDTH = 8;

    logic               clk;
    logic               reset_a;
    logic [WIDTH-1:0]   dataa;
    logic [WIDTH-1:0]   datab;
    logic [1:0]         input_sel;
    logic [1:0]         shift_sel;
    logic               clk_ena;
    logic               sclr_n;
    logic [1:0]         count;
    logic [2*WIDTH-1:0] product;
    logic               product_valid;
    logic               seq_err;

    int checks;
    int errors;

    multiplier_datapath #(
        .WIDTH(WIDTH)
    ) dut (
        .clk(clk),
        .reset_a(reset_a),
        .dataa(dataa),
        .datab(datab),
        .input_sel(input_sel),
        .shift_sel(shift_sel),
        .clk_ena(clk_ena),
        .sclr_n(sclr_n),
        .count(count),
        .product(product),
        .product_valid(product_valid),
        .seq_err(seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of controller signals and sample 1ns after the edge
    task automatic applyStimulus(input logic clr_n, input logic ena, input logic [1:0] isel, input logic [1:0] ssel);
        sclr_n    = clr_n;
        clk_ena   = ena;
        input_sel = isel;
        shift_sel = ssel;
        @(posedge clk);
        #1;
        sclr_n  = 1'b1;
        clk_ena = 1'b0;
    endtask

    task automatic startOp(input logic [7:0] a, input logic [7:0] b);
        dataa = a;
        datab = b;
        applyStimulus(1'b0, 1'b0, SEL_LL, SHIFT_0);
        checkOutput("clr_product", 32'(product), 32'h0);
        checkOutput("clr_count", 32'(count), 32'd0);
        checkOutput("clr_valid", 32'(product_valid), 32'd0);
    endtask

    task automatic runLegal(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        startOp(a, b);
        applyStimulus(1'b1, 1'b1, SEL_LL, SHIFT_0);
        checkOutput({tag, "_s1"}, 32'(product), 32'(e0));
        checkOutput({tag, "_c1"}, 32'(count), 32'd1);
        checkOutput({tag, "_v1"}, 32'(product_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, SEL_LH, SHIFT_HALF);
        checkOutput({tag, "_s2"}, 32'(product), 32'(e1));
        checkOutput({tag, "_c2"}, 32'(count), 32'd2);
        applyStimulus(1'b1, 1'b1, SEL_HL, SHIFT_HALF);
        checkOutput({tag, "_s3"}, 32'(product), 32'(e2));
        checkOutput({tag, "_c3"}, 32'(count), 32'd3);
        checkOutput({tag, "_v3"}, 32'(product_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, SEL_HH, SHIFT_FULL);
        checkOutput({tag, "_s4"}, 32'(product), 32'(e3));
        checkOutput({tag, "_c4"}, 32'(count), 32'd0);
        checkOutput({tag, "_v4"}, 32'(product_valid), 32'd1);
        checkOutput({tag, "_err"}, 32'(seq_err), 32'd0);
        applyStimulus(1'b1, 1'b0, SEL_LL, SHIFT_0);
        checkOutput({tag, "_hold"}, 32'(product), 32'(e3));
        checkOutput({tag, "_holdv"}, 32'(product_valid), 32'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_a   = 1'b0;
        dataa     = '0;
        datab     = '0;
        input_sel = SEL_LL;
        shift_sel = SHIFT_0;
        clk_ena   = 1'b0;
        sclr_n    = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_product", 32'(product), 32'h0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_valid", 32'(product_valid), 32'd0);
        checkOutput("rst_err", 32'(seq_err), 32'd0);
        reset_a = 1'b1;

        runLegal("a12b34", 8'h12, 8'h34, 16'h0008, 16'h0068, 16'h00A8, 16'h03A8);

        // Fifth step without a clear keeps accumulating and drops valid
        applyStimulus(1'b1, 1'b1, SEL_LL, SHIFT_0);
        checkOutput("step5_product", 32'(product), 32'h03B0);
        checkOutput("step5_count", 32'(count), 32'd1);
        checkOutput("step5_valid", 32'(product_valid), 32'd0);

        runLegal("aFFbFF", 8'hFF, 8'hFF, 16'h00E1, 16'h0EF1, 16'h1D01, 16'hFE01);
        runLegal("a00bB7", 8'h00, 8'hB7, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // Stall between steps 2 and 3 while the operand inputs change
        startOp(8'h12, 8'h34);
        applyStimulus(1'b1, 1'b1, SEL_LL, SHIFT_0);
        applyStimulus(1'b1, 1'b1, SEL_LH, SHIFT_HALF);
        dataa = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, SEL_HL, SHIFT_HALF);
            checkOutput("stall_product", 32'(product), 32'h0068);
            checkOutput("stall_count", 32'(count), 32'd2);
        end
        applyStimulus(1'b1, 1'b1, SEL_HL, SHIFT_HALF);
        applyStimulus(1'b1, 1'b1, SEL_HH, SHIFT_FULL);
        checkOutput("stall_final", 32'(product), 32'h03A8);
        checkOutput("stall_valid", 32'(product_valid), 32'd1);

        // SHIFT_NONE step leaves the accumulator alone but advances count
        startOp(8'h12, 8'h34);
        applyStimulus(1'b1, 1'b1, SEL_LL, SHIFT_0);
        applyStimulus(1'b1, 1'b1, SEL_LH, SHIFT_NONE);
        checkOutput("none_product", 32'(product), 32'h0008);
        checkOutput("none_count", 32'(count), 32'd2);

        // Clear and step together: clear wins
        dataa = 8'h12;
        datab = 8'h34;
        applyStimulus(1'b0, 1'b1, SEL_LL, SHIFT_0);
        checkOutput("clrena_product", 32'(product), 32'h0);
        checkOutput("clrena_count", 32'(count), 32'd0);

        // Asynchronous reset mid-operation
        applyStimulus(1'b1, 1'b1, SEL_LL, SHIFT_0);
        applyStimulus(1'b1, 1'b1, SEL_LH, SHIFT_HALF);
        checkOutput("pre_rst_product", 32'(product), 32'h0068);
        #2;
        reset_a = 1'b0;
        #1;
        checkOutput("async_product", 32'(product), 32'h0);
        checkOutput("async_count", 32'(count), 32'd0);
        checkOutput("async_valid", 32'(product_valid), 32'd0);
        checkOutput("async_err", 32'(seq_err), 32'd0);
        reset_a = 1'b1;
        runLegal("a03b05", 8'h03, 8'h05, 16'h000F, 16'h000F, 16'h000F, 16'h000F);

        // Out-of-order select sets the sticky error until the next clear
        startOp(8'h12, 8'h34);
        applyStimulus(1'b1, 1'b1, SEL_LL, SHIFT_0);
        checkOutput("seq_ok", 32'(seq_err), 32'd0);
        applyStimulus(1'b1, 1'b1, SEL_HL, SHIFT_HALF);
        checkOutput("seq_set", 32'(seq_err), 32'd1);
        applyStimulus(1'b1, 1'b1, SEL_HL, SHIFT_HALF);
        checkOutput("seq_sticky1", 32'(seq_err), 32'd1);
        applyStimulus(1'b1, 1'b1, SEL_HH, SHIFT_FULL);
        checkOutput("seq_sticky2", 32'(seq_err), 32'd1);
        applyStimulus(1'b1, 1'b0, SEL_LL, SHIFT_0);
        checkOutput("seq_sticky3", 32'(seq_err), 32'd1);
        applyStimulus(1'b0, 1'b0, SEL_LL, SHIFT_0);
        checkOutput("seq_cleared", 32'(seq_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier_datapath.md
Name: multiplier_datapath

Overview:
- Responder side of the multiplier control interface. Consumes input_sel, shift_sel, clk_ena and sclr_n from the multiplier controller, and returns the 2-bit step count the controller sequences on.
- Computes an unsigned WIDTH x WIDTH product over four cycles with one shared (WIDTH/2) x (WIDTH/2) multiplier. Partial products are shifted and added into an accumulator.
- Sits between the operand inputs and the product output/display logic.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and at least 4. HALF = WIDTH/2.

Ports:
- clk  input  1  clock, rising edge.
- reset_a  input  1  asynchronous, active-low reset.
- dataa  input  WIDTH  operand A, unsigned.
- datab  input  WIDTH  operand B, unsigned.
- input_sel  input  2  partial-product select: 00 Alo*Blo, 01 Alo*Bhi, 10 Ahi*Blo, 11 Ahi*Bhi.
- shift_sel  input  2  partial-product shift: 00 <<0, 01 <<HALF, 10 <<WIDTH, 11 contributes zero.
- clk_ena  input  1  step enable.
- sclr_n  input  1  synchronous clear/load, active-low.
- count  output  2  step counter returned to the controller.
- product  output  2*WIDTH  accumulator value.
- product_valid  output  1  product holds a complete result.
- seq_err  output  1  sticky flag: a step was taken with input_sel not equal to count.

Behaviour:
- Reset (reset_a=0, asynchronous): operand regs, product, count, product_valid and seq_err all go to 0.
- Each rising edge, in priority order:
  1. sclr_n=0 (regardless of clk_ena): product<=0, count<=0, product_valid<=0, seq_err<=0, opA<=dataa, opB<=datab.
  2. sclr_n=1 and clk_ena=1 (step):
     - product <= product + (pp << shift), where pp = mult4x4(selected nibbles of the registered operands).
     - Sum is truncated to 2*WIDTH. It cannot overflow in a legal sequence.
     - count <= count+1, wrapping 3 -> 0.
     - seq_err <= seq_err | (input_sel != count).
     - product_valid <= 1 exactly when count==3 on this step; otherwise product_valid <= 0.
  3. sclr_n=1 and clk_ena=0: all registers hold.
- Operands are sampled only on the clear cycle. dataa/datab changes after that do not affect the operation in flight.
- Datapath is combinational from the operand regs through the adder, so a step's result appears in product on the following edge. There is no extra pipeline stage.
- Legal sequence from the controller: clear (start), then steps at count 0,1,2,3 with input_sel 00,01,10,11 and shift_sel 00,01,01,10.
  - After the 4th step edge: product = A*B, product_valid=1, count=0.
  - The controller's done cycle has clk_ena=0, so product is held.
- Total latency: 5 edges from the clear edge to product_valid=1.
- shift_sel=11 during a step: accumulator unchanged, but count still advances.
- A 5th step without a clear: accumulates normally, count advances 0->1, and product_valid drops.
- Reset mid-operation: every register is cleared immediately. No partial result survives.
- Simultaneous sclr_n=0 and clk_ena=1: the clear wins and no accumulation happens.

Decomposition:
- Shared package holds:
  - SEL_LL=2'b00, SEL_LH=2'b01, SEL_HL=2'b10, SEL_HH=2'b11.
  - SHIFT_0=2'b00, SHIFT_HALF=2'b01, SHIFT_FULL=2'b10, SHIFT_NONE=2'b11.
  - These constants are used by both the controller and this block.
- One sub-module: mult4x4, a combinational unsigned HALF x HALF -> WIDTH multiplier, parameterised by HALF.
- The operand mux, shifter, adder and counter stay inline.

Test Plan:
- Legal sequence, A=0x12, B=0x34 -> product after each step: 0x0008, 0x0068, 0x00A8, 0x03A8. product_valid=1 only after step 4; count sequence 1,2,3,0; seq_err=0.
- A=0xFF, B=0xFF, legal sequence -> product=0xFE01, product_valid=1, no truncation.
- A=0x00, B=0xB7 -> product stays 0x0000 every step; product_valid=1 after step 4.
- A=0x12, B=0x34, clk_ena=0 for 3 cycles between steps 2 and 3; also drive dataa=0xFF mid-operation -> product holds 0x0068 during the stall, count holds 2, final product 0x03A8.
- Pulse reset_a low after step 2, then run a new sequence with A=0x03, B=0x05 -> immediately after the reset: product=0, count=0, flags 0. Final product 0x000F.
- On step 2 drive input_sel=10 while count=1 -> seq_err=1 and stays 1 until the next sclr_n=0 cycle clears it.
